// File: rtl/skein_search_ctrl.sv
// Nonce-search controller: launches nonces on free hash lanes, compares returned
// hashes against a target by Hamming distance and keeps the closest result.
module skein_search_ctrl #(
    parameter int  NUM_LANES = 4,
    parameter int  HASH_W    = 1024,
    parameter int  NONCE_W   = 64,
    localparam int DIST_W    = $clog2(HASH_W + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic [HASH_W-1:0]              target_i,
    input  logic [NONCE_W-1:0]             nonce_base_i,
    input  logic [DIST_W-1:0]              threshold_i,
    output logic [NUM_LANES-1:0]           lane_start_o,
    output logic [NUM_LANES*NONCE_W-1:0]   lane_nonce_o,
    input  logic [NUM_LANES-1:0]           lane_ready_i,
    input  logic [NUM_LANES*HASH_W-1:0]    lane_hash_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           found_o,
    output logic                           best_valid_o,
    output logic [DIST_W-1:0]              best_dist_o,
    output logic [NONCE_W-1:0]             best_nonce_o,
    output logic [NONCE_W-1:0]             issued_o
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
    typedef enum logic [1:0] {L_FREE, L_BUSY, L_PEND} lane_state_t;

    state_t              state_q, state_d;
    lane_state_t         lane_st_q    [NUM_LANES];
    logic [NONCE_W-1:0]  lane_nonce_q [NUM_LANES];

    logic [NONCE_W-1:0]  ctr_q, base_q, issued_q, best_nonce_q, s1_nonce_q;
    logic [DIST_W-1:0]   best_dist_q, s1_dist_q;
    logic                s1_valid_q, found_q, best_valid_q, done_q;
    logic [LANE_W-1:0]   last_gnt_q;

    logic                launch_hit, launch, wrap_last, start_accept, all_free;
    logic [LANE_W-1:0]   launch_idx, gnt_idx;
    logic                gnt_hit, gnt;
    logic [NONCE_W-1:0]  ctr_next;
    logic [HASH_W-1:0]   gnt_hash;
    logic [DIST_W-1:0]   gnt_dist, new_best;
    logic                upd;

    // Lowest-indexed FREE lane: later (lower) iterations overwrite earlier ones.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch is inferred.
        launch_hit = 1'b0;
        launch_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_st_q[i] == L_FREE) begin
                launch_hit = 1'b1;
                launch_idx = LANE_W'(i);
            end
        end
    end

    // Round-robin over PEND lanes, beginning just after the last grant.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = last_gnt_q;
        for (int i = 1; i <= NUM_LANES; i++) begin
            if (!gnt_hit && lane_st_q[(int'(last_gnt_q) + i) % NUM_LANES] == L_PEND) begin
                gnt_hit = 1'b1;
                gnt_idx = LANE_W'((int'(last_gnt_q) + i) % NUM_LANES);
            end
        end
    end

    always_comb begin
        all_free = 1'b1;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane_st_q[i] != L_FREE) all_free = 1'b0;
        end
    end

    assign start_accept = (state_q == S_IDLE) && start_i;
    assign launch       = (state_q == S_RUN) && !found_q && launch_hit;
    assign ctr_next     = ctr_q + NONCE_W'(1);
    assign wrap_last    = launch && (ctr_next == base_q);
    assign gnt          = gnt_hit && (state_q != S_IDLE);
    assign gnt_hash     = lane_hash_i[int'(gnt_idx) * HASH_W +: HASH_W];
    assign gnt_dist     = DIST_W'($countones(gnt_hash ^ target_i));

    // Strict less-than: an equal distance never displaces the earlier result.
    assign upd      = s1_valid_q && (!best_valid_q || (s1_dist_q < best_dist_q));
    assign new_best = upd ? s1_dist_q : best_dist_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (stop_i || found_q || wrap_last) state_d = S_DRAIN;
            S_DRAIN: if (all_free && !s1_valid_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            // NOTE: lane nonce registers feed outputs directly, so they are reset too.
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_st_q[i]    <= L_FREE;
                lane_nonce_q[i] <= '0;
            end
            ctr_q        <= '0;
            base_q       <= '0;
            issued_q     <= '0;
            found_q      <= 1'b0;
            best_valid_q <= 1'b0;
            best_dist_q  <= '1;
            best_nonce_q <= '0;
            s1_valid_q   <= 1'b0;
            s1_dist_q    <= '0;
            s1_nonce_q   <= '0;
            last_gnt_q   <= LANE_W'(NUM_LANES - 1);
            done_q       <= 1'b0;
        end else begin
            done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);

            for (int i = 0; i < NUM_LANES; i++) begin
                case (lane_st_q[i])
                    L_FREE: if (launch && launch_idx == LANE_W'(i)) begin
                        lane_st_q[i]    <= L_BUSY;
                        lane_nonce_q[i] <= ctr_q;
                    end
                    L_BUSY: if (lane_ready_i[i]) lane_st_q[i] <= L_PEND;
                    L_PEND: if (gnt && gnt_idx == LANE_W'(i)) lane_st_q[i] <= L_FREE;
                    default: lane_st_q[i] <= L_FREE;
                endcase
            end

            if (launch) begin
                ctr_q    <= ctr_next;
                issued_q <= issued_q + NONCE_W'(1);
            end

            s1_valid_q <= gnt;
            if (gnt) begin
                s1_dist_q  <= gnt_dist;
                s1_nonce_q <= lane_nonce_q[gnt_idx];
                last_gnt_q <= gnt_idx;
            end

            if (s1_valid_q) begin
                best_valid_q <= 1'b1;
                found_q      <= found_q | (new_best <= threshold_i);
                if (upd) begin
                    best_dist_q  <= s1_dist_q;
                    best_nonce_q <= s1_nonce_q;
                end
            end

            if (start_accept) begin
                ctr_q        <= nonce_base_i;
                base_q       <= nonce_base_i;
                issued_q     <= '0;
                found_q      <= 1'b0;
                best_valid_q <= 1'b0;
                best_dist_q  <= '1;
                best_nonce_q <= '0;
            end
        end
    end

    // The launching lane shows the live counter so its nonce is valid during the pulse.
    always_comb begin
        lane_start_o = '0;
        lane_nonce_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_start_o[i] = launch && (launch_idx == LANE_W'(i));
            lane_nonce_o[i*NONCE_W +: NONCE_W] = lane_start_o[i] ? ctr_q : lane_nonce_q[i];
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign found_o      = found_q;
    assign best_valid_o = best_valid_q;
    assign best_dist_o  = best_dist_q;
    assign best_nonce_o = best_nonce_q;
    assign issued_o     = issued_q;

endmodule
